// File: rtl/fetch_stage_pkg.sv
// Shared constants, state encodings and payload types for the instruction-fetch stage.
// Imported by fetch_stage and its IF/ID pipeline register.
package fetch_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OPW    = 6;
  localparam int unsigned OP_LSB = 26;

  localparam logic [XLEN-1:0] RESET_PC   = 32'h0040_0000;
  localparam logic [XLEN-1:0] EXC_VECTOR = 32'h8000_0180;
  localparam logic [XLEN-1:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP    = 32'd4;

  typedef enum logic {
    RUN     = 1'b0,
    PENDING = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus_4;
  } if_id_t;

  // Sequential PC; wraps modulo 2^32 with the low bits carried untouched
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return XLEN'(pc + PC_STEP);
  endfunction

  function automatic logic [OPW-1:0] opcode_of(input logic [XLEN-1:0] instr);
    return instr[OP_LSB +: OPW];
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: clear (bubble/kill) beats load; neither means hold.
// A cleared entry keeps its pc_plus_4 so only valid/instr change on a bubble.
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   load,
  input  logic   clear,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clock) begin
    if (reset) begin
      q.valid     <= 1'b0;
      q.instr     <= NOP_INSTR;
      q.pc_plus_4 <= RESET_PC;
    end else if (clear) begin
      q.valid <= 1'b0;
      q.instr <= NOP_INSTR;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, tracks a redirect that could not be taken yet,
// and feeds the IF/ID register. Delay-slot words are always delivered before a redirect.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [OPW-1:0]  id_opcode,
  output logic [XLEN-1:0] id_pc_plus_4
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pend_target;
  logic            fetch_done;
  logic            id_clear;
  if_id_t          id_d;
  if_id_t          id_q;

  assign fetch_done = imem_ready & ~stall & ~flush;
  // Wait states insert a NOP bubble; a stall freezes IF/ID even if memory is idle
  assign id_clear   = flush | (~stall & ~imem_ready);

  assign id_d.valid     = 1'b1;
  assign id_d.instr     = imem_rdata;
  assign id_d.pc_plus_4 = pc_inc(pc);

  // PC and redirect tracking: a redirect that cannot complete this cycle is parked
  always_ff @(posedge clock) begin
    if (reset) begin
      pc          <= RESET_PC;
      state       <= RUN;
      pend_target <= '0;
    end else if (flush) begin
      pc          <= EXC_VECTOR;
      state       <= RUN;
      pend_target <= '0;
    end else if (fetch_done) begin
      state <= RUN;
      if (redirect_valid) begin
        pc <= redirect_target;
      end else if (state == PENDING) begin
        pc <= pend_target;
      end else begin
        pc <= pc_inc(pc);
      end
    end else if (redirect_valid) begin
      state       <= PENDING;
      pend_target <= redirect_target;
    end
  end

  fetch_stage_if_id_reg u_if_id (
    .clock (clock),
    .reset (reset),
    .load  (fetch_done),
    .clear (id_clear),
    .d     (id_d),
    .q     (id_q)
  );

  assign imem_addr    = pc;
  assign id_valid     = id_q.valid;
  assign id_instr     = id_q.instr;
  assign id_opcode    = opcode_of(id_q.instr);
  assign id_pc_plus_4 = id_q.pc_plus_4;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboarded bench for fetch_stage: stimulus queues expected IF/ID contents,
// a monitor retires them whenever decode consumes a valid, unstalled instruction.
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready = 1'b1;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [5:0]  id_opcode;
  logic [31:0] id_pc_plus_4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  fetch_stage dut (
    .clock           (clock),
    .reset           (reset),
    .stall           (stall),
    .flush           (flush),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .imem_ready      (imem_ready),
    .id_valid        (id_valid),
    .id_instr        (id_instr),
    .id_opcode       (id_opcode),
    .id_pc_plus_4    (id_pc_plus_4)
  );

  // Memory image: each word is the bitwise inverse of its address
  assign imem_rdata = ~imem_addr;

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc4);
    exp_t e;
    e.instr = instr;
    e.pc4   = pc4;
    exp_q.push_back(e);
  endtask

  // Decode consumes the IF/ID word in any valid cycle that is not stalled or flushed
  always @(negedge clock) begin : monitor
    exp_t e;
    if (!reset && id_valid && !stall && !flush) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL id_unexpected: got %h expected none", id_instr);
      end else begin
        e = exp_q.pop_front();
        chk("id_instr", id_instr, e.instr);
        chk("id_pc_plus_4", id_pc_plus_4, e.pc4);
        chk("id_opcode", {26'd0, id_opcode}, {26'd0, e.instr[31:26]});
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    cyc();
    cyc();
    chk("rst_imem_addr", imem_addr, 32'h0040_0000);
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_id_instr", id_instr, 32'd0);
    chk("rst_id_opcode", {26'd0, id_opcode}, 32'd0);
    chk("rst_id_pc_plus_4", id_pc_plus_4, 32'h0040_0000);

    // Sequential fetch, then branch at 0x400000 redirects while fetching its delay slot
    reset = 1'b0;
    chk("a_addr", imem_addr, 32'h0040_0000);
    push(~32'h0040_0000, 32'h0040_0004);
    cyc();
    chk("b_addr", imem_addr, 32'h0040_0004);
    chk("b_id_pc_plus_4", id_pc_plus_4, 32'h0040_0004);
    chk("b_id_valid", {31'd0, id_valid}, 32'd1);
    redirect_valid = 1'b1;
    redirect_target = 32'h0040_0100;
    push(~32'h0040_0004, 32'h0040_0008);
    cyc();
    chk("c_addr", imem_addr, 32'h0040_0100);
    redirect_valid = 1'b0;
    push(~32'h0040_0100, 32'h0040_0104);
    cyc();

    // Redirect during a 3-cycle memory wait: PC holds on the delay slot
    chk("d_addr", imem_addr, 32'h0040_0104);
    imem_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'h0040_0200;
    cyc();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wait_addr", imem_addr, 32'h0040_0104);
      chk("wait_id_valid", {31'd0, id_valid}, 32'd0);
      if (i < 2) cyc();
    end
    imem_ready = 1'b1;
    push(~32'h0040_0104, 32'h0040_0108);
    cyc();
    chk("h_addr", imem_addr, 32'h0040_0200);
    push(~32'h0040_0200, 32'h0040_0204);
    cyc();

    // Two stall cycles with memory toggling
    chk("i_addr", imem_addr, 32'h0040_0204);
    stall = 1'b1;
    imem_ready = 1'b0;
    cyc();
    chk("stall1_addr", imem_addr, 32'h0040_0204);
    chk("stall1_instr", id_instr, ~32'h0040_0200);
    chk("stall1_valid", {31'd0, id_valid}, 32'd1);
    imem_ready = 1'b1;
    cyc();
    chk("stall2_addr", imem_addr, 32'h0040_0204);
    chk("stall2_instr", id_instr, ~32'h0040_0200);
    chk("stall2_valid", {31'd0, id_valid}, 32'd1);
    stall = 1'b0;
    push(~32'h0040_0204, 32'h0040_0208);
    cyc();

    // Stalled redirect goes PENDING, then a flush under stall overrides it
    chk("l_addr", imem_addr, 32'h0040_0208);
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h0040_0300;
    cyc();
    chk("m_addr", imem_addr, 32'h0040_0208);
    redirect_valid = 1'b0;
    flush = 1'b1;
    void'(exp_q.pop_back());
    cyc();
    chk("flush_addr", imem_addr, 32'h8000_0180);
    chk("flush_id_valid", {31'd0, id_valid}, 32'd0);
    chk("flush_id_instr", id_instr, 32'd0);
    flush = 1'b0;
    stall = 1'b0;
    push(~32'h8000_0180, 32'h8000_0184);
    cyc();
    chk("post_flush_addr", imem_addr, 32'h8000_0184);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    push(~32'h8000_0184, 32'h8000_0188);
    cyc();
    chk("p_addr", imem_addr, 32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    push(~32'hFFFF_FFFC, 32'h0000_0000);
    cyc();
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    chk("wrap_id_pc_plus_4", id_pc_plus_4, 32'h0000_0000);
    push(~32'h0000_0000, 32'h0000_0004);
    cyc();

    // Reset while PENDING drops the parked target
    chk("r_addr", imem_addr, 32'h0000_0004);
    imem_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'h0040_0500;
    cyc();
    chk("s_addr", imem_addr, 32'h0000_0004);
    redirect_valid = 1'b0;
    reset = 1'b1;
    imem_ready = 1'b1;
    cyc();
    reset = 1'b0;
    chk("t_addr", imem_addr, 32'h0040_0000);
    push(~32'h0040_0000, 32'h0040_0004);
    cyc();

    // Back-to-back redirects while waiting: the newer target wins
    chk("u_addr", imem_addr, 32'h0040_0004);
    imem_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'h0040_0600;
    cyc();
    redirect_target = 32'h0040_0700;
    cyc();
    redirect_valid = 1'b0;
    imem_ready = 1'b1;
    chk("w_addr", imem_addr, 32'h0040_0004);
    chk("w_id_valid", {31'd0, id_valid}, 32'd0);
    push(~32'h0040_0004, 32'h0040_0008);
    cyc();
    chk("overwrite_addr", imem_addr, 32'h0040_0700);
    imem_ready = 1'b0;
    cyc();
    cyc();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
